regfile_scoreboard: RTL and testbench



---
 rtl/riscv_pkg.sv | 8 +
 rtl/reg_scoreboard.sv | 54 +++++
 rtl/regfile_scoreboard.sv | 86 ++++++++
 tb/tb_regfile_scoreboard.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared register-file constants and index type for the integer pipeline.
package riscv_pkg;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;
    localparam int REG_ZERO   = 0;

    typedef logic [ADDR_WIDTH-1:0] reg_idx_t;
endpackage

// File: rtl/reg_scoreboard.sv
// Write-pending scoreboard: one pending bit per register, set at issue and
// cleared at writeback, with three combinational lookups and a sticky error.
module reg_scoreboard
    import riscv_pkg::*;
#(
    parameter int SB_ADDR_WIDTH = riscv_pkg::ADDR_WIDTH,
    parameter int SB_NUM_REGS   = riscv_pkg::NUM_REGS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [SB_ADDR_WIDTH-1:0] set_idx,
    input  logic                     clr_en,
    input  logic [SB_ADDR_WIDTH-1:0] clr_idx,
    input  logic [SB_ADDR_WIDTH-1:0] look_a,
    input  logic [SB_ADDR_WIDTH-1:0] look_b,
    input  logic [SB_ADDR_WIDTH-1:0] look_c,
    output logic                     pend_a,
    output logic                     pend_b,
    output logic                     pend_c,
    output logic                     sb_error
);
    localparam logic [SB_ADDR_WIDTH-1:0] ZERO_IDX = SB_ADDR_WIDTH'(REG_ZERO);

    logic [SB_NUM_REGS-1:0] sb;
    logic [SB_NUM_REGS-1:0] sb_next;
    logic                   clr_live;
    logic                   set_live;

    assign clr_live = clr_en && (clr_idx != ZERO_IDX);
    assign set_live = set_en && (set_idx != ZERO_IDX);

    // Clear is applied first so a same-edge set of that register wins.
    always_comb begin
        sb_next = sb;
        if (clr_live) sb_next[clr_idx] = 1'b0;
        if (set_live) sb_next[set_idx] = 1'b1;
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb       <= '0;
            sb_error <= 1'b0;
        end else begin
            sb <= sb_next;
            if (clr_live && !sb[clr_idx]) sb_error <= 1'b1;
        end
    end

    assign pend_a = sb[look_a];
    assign pend_b = sb[look_b];
    assign pend_c = sb[look_c];
endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file with write-pending scoreboard and a single decode stall.
// Optional macro WB_BYPASS_EN forwards the writeback value to same-cycle reads.
module regfile_scoreboard
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = riscv_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = riscv_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  issue_valid,
    input  logic                  issue_we,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    output logic                  hazard_stall,
    output logic                  sb_error
);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  pend_rs1;
    logic                  pend_rs2;
    logic                  pend_rd;
    logic                  hit1;
    logic                  hit2;
    logic                  rd_busy;
    logic                  issue_accept;

    // Issue handshake: decode holds issue_valid and its fields stable; the
    // instruction is taken on a rising edge where hazard_stall is low.
    assign issue_accept = issue_valid && !hazard_stall;

    reg_scoreboard #(
        .SB_ADDR_WIDTH(ADDR_WIDTH),
        .SB_NUM_REGS  (NUM_REGS)
    ) u_sb (
        .clk     (clk),
        .rst     (rst),
        .set_en  (issue_accept && issue_we),
        .set_idx (issue_rd),
        .clr_en  (wb_valid),
        .clr_idx (wb_rd),
        .look_a  (rs1_addr),
        .look_b  (rs2_addr),
        .look_c  (issue_rd),
        .pend_a  (pend_rs1),
        .pend_b  (pend_rs2),
        .pend_c  (pend_rd),
        .sb_error(sb_error)
    );

`ifdef WB_BYPASS_EN
    assign hit1 = wb_valid && (wb_rd == rs1_addr) && (rs1_addr != ZERO_IDX);
    assign hit2 = wb_valid && (wb_rd == rs2_addr) && (rs2_addr != ZERO_IDX);
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_valid && (wb_rd != ZERO_IDX)) begin
            regs[wb_rd] <= wb_data;
        end
    end

    assign rs1_data = (rs1_addr == ZERO_IDX) ? '0 : (hit1 ? wb_data : regs[rs1_addr]);
    assign rs2_data = (rs2_addr == ZERO_IDX) ? '0 : (hit2 ? wb_data : regs[rs2_addr]);

    assign rs1_busy = pend_rs1 && !hit1;
    assign rs2_busy = pend_rs2 && !hit2;
    // A writeback to the same rd in this cycle retires the older write, so WAW is clear.
    assign rd_busy  = issue_we && pend_rd && !(wb_valid && (wb_rd == issue_rd));

    assign hazard_stall = issue_valid && (rs1_busy || rs2_busy || rd_busy);
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: driver pushes expected outputs, a
// negedge monitor pops and compares them.
module tb_regfile_scoreboard;
    import riscv_pkg::*;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int EW = 2 * DW + 4;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    reg_idx_t      rs1_addr, rs2_addr, issue_rd, wb_rd;
    logic [DW-1:0] rs1_data, rs2_data, wb_data;
    logic          issue_valid, issue_we, wb_valid;
    logic          rs1_busy, rs2_busy, hazard_stall, sb_error;

    logic [EW-1:0] exp_q[$];
    string         tag_q[$];
    int            chk_cnt  = 0;
    int            pass_cnt = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.DATA_WIDTH(DW), .NUM_REGS(32), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data),
        .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .hazard_stall(hazard_stall), .sb_error(sb_error)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic iwe, input reg_idx_t ird,
                         input logic wv, input reg_idx_t wrd, input logic [DW-1:0] wd,
                         input reg_idx_t a1, input reg_idx_t a2);
        issue_valid = iv;
        issue_we    = iwe;
        issue_rd    = ird;
        wb_valid    = wv;
        wb_rd       = wrd;
        wb_data     = wd;
        rs1_addr    = a1;
        rs2_addr    = a2;
    endtask

    task automatic expect_out(input string tag, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                              input logic b1, input logic b2, input logic st, input logic err);
        exp_q.push_back({d1, d2, b1, b2, st, err});
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [EW-1:0] exp_v;
            logic [EW-1:0] act_v;
            string         tag;
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            act_v = {rs1_data, rs2_data, rs1_busy, rs2_busy, hazard_stall, sb_error};
            chk_cnt++;
            if (act_v === exp_v) begin
                pass_cnt++;
            end else begin
                $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b stall=%b err=%b, want d1=%h d2=%h b1=%b b2=%b stall=%b err=%b",
                         tag, act_v[EW-1 -: DW], act_v[DW+3 -: DW], act_v[3], act_v[2], act_v[1], act_v[0],
                         exp_v[EW-1 -: DW], exp_v[DW+3 -: DW], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        expect_out("reset_hold", 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            drive(1, 0, 0, 0, 0, 0, reg_idx_t'(i), reg_idx_t'(31 - i));
            expect_out($sformatf("read_after_reset_x%0d", i), 0, 0, 0, 0, 0, 0);
            next_cycle();
        end

        // RAW on x5: issue, two waiting cycles, writeback, then resolved.
        drive(1, 1, 5, 0, 0, 0, 5, 0);
        expect_out("issue_rd5", 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 5, 5);
        expect_out("raw_wait1", 0, 0, 1, 1, 1, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 5, 0);
        expect_out("raw_wait2", 0, 0, 1, 0, 1, 0);
        next_cycle();
        drive(1, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
        expect_out("raw_wb_cycle", BYP ? 32'hDEADBEEF : 32'h0, 0, !BYP, 0, !BYP, 0);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 5, 5);
        expect_out("raw_after_wb", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0, 0);
        next_cycle();

        // WAW on x7: stalled without wb, accepted with same-cycle wb (set wins).
        drive(1, 1, 7, 0, 0, 0, 0, 0);
        expect_out("issue_rd7", 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(1, 1, 7, 0, 0, 0, 0, 0);
        expect_out("waw_stall", 0, 0, 0, 0, 1, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 7, 0);
        expect_out("waw_still_pending", 0, 0, 1, 0, 0, 0);
        next_cycle();
        drive(1, 1, 7, 1, 7, 32'h77, 0, 0);
        expect_out("waw_wb_same_cycle", 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 7, 0);
        expect_out("set_wins_pending", 32'h77, 0, 1, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 1, 7, 32'h78, 7, 0);
        expect_out("x7_final_wb", BYP ? 32'h78 : 32'h77, 0, !BYP, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 7, 0);
        expect_out("x7_committed", 32'h78, 0, 0, 0, 0, 0);
        next_cycle();

        // x0 writes are dropped without error; unpending write sets sticky error.
        drive(0, 0, 0, 1, 0, 32'h1234, 0, 0);
        expect_out("wb_x0_cycle", 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("x0_reads_zero", 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 1, 9, 32'hCAFE0009, 9, 0);
        expect_out("wb_x9_unpending", BYP ? 32'hCAFE0009 : 32'h0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 9, 0);
        expect_out("sb_error_set", 32'hCAFE0009, 0, 0, 0, 0, 1);
        next_cycle();
        drive(1, 0, 0, 0, 0, 0, 0, 9);
        expect_out("sb_error_sticky", 0, 32'hCAFE0009, 0, 0, 0, 1);
        next_cycle();

        // Mid-operation reset with x3/x4 pending and a writeback in flight.
        drive(1, 1, 3, 0, 0, 0, 0, 0);
        expect_out("issue_rd3", 0, 0, 0, 0, 0, 1);
        next_cycle();
        drive(1, 1, 4, 0, 0, 0, 0, 0);
        expect_out("issue_rd4", 0, 0, 0, 0, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 3, 4);
        expect_out("x3_x4_pending", 0, 0, 1, 1, 0, 1);
        next_cycle();
        drive(1, 1, 4, 1, 10, 32'h1010, 3, 4);
        rst = 1'b1;
        expect_out("async_reset_clears", 0, 0, 0, 0, 0, 0);
        next_cycle();
        rst = 1'b0;
        drive(1, 1, 3, 0, 0, 0, 9, 10);
        expect_out("post_reset_issue_rd3", 0, 0, 0, 0, 0, 0);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 3, 0);
        expect_out("post_reset_rd3_pending", 0, 0, 1, 0, 0, 0);
        next_cycle();

        repeat (4) @(posedge clk);
        if (exp_q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
